dmem_arbiter: RTL

Two-port arbiter and sequencer for the single-port 1024×32 `datamemory` synchronous RAM. It shares the RAM between the CPU load/store path (port 0) and a debug/DMA requester (port 1). It uses a req/ack handshake, round-robin priority and a fixed-latency FSM. Only this block drives the RAM's `address`, `data` and `wren` inputs, and it registers the RAM's `q` back to the winning requester.

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter_rr_arbiter2.sv | 28 ++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, FSM encodings and the latched memory-operation type
// for the datamemory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_op_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports, the RAM-side signals and the status outputs.
// The slave modport is the arbiter's view.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = dmem_arbiter_pkg::ADDR_W,
    parameter int unsigned DATA_W = dmem_arbiter_pkg::DATA_W
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    logic              busy;
    logic              grant_id;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_q,
        output p0_ack, p0_rdata, p1_ack, p1_rdata,
        output mem_address, mem_data, mem_wren,
        output busy, grant_id
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_q,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata,
        input  mem_address, mem_data, mem_wren,
        input  busy, grant_id
    );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic; purely combinational, the caller owns the
// pointer register. prio_i names the port favoured on a tie.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o,
    output logic       prio_o
);

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase

        // The port just granted loses the next tie.
        prio_o = prio_i;
        if (gnt_o[0]) begin
            prio_o = 1'b1;
        end else if (gnt_o[1]) begin
            prio_o = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port datamemory RAM between two req/ack requesters with
// round-robin priority and a fixed IDLE/ISSUE/WAIT/DONE sequence.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    logic [1:0]        state_q, state_d;
    logic              prio_q, prio_d;
    logic              grant_q, grant_d;
    mem_op_t           op_q, op_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [1:0]        gnt;
    logic              prio_nxt;

    rr_arbiter2 u_rr (
        .req_i  ({bus.p1_req, bus.p0_req}),
        .prio_i (prio_q),
        .gnt_o  (gnt),
        .prio_o (prio_nxt)
    );

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        grant_d  = grant_q;
        op_d     = op_q;
        wren_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            StIdle: begin
                if (gnt != 2'b00) begin
                    grant_d = gnt[1];
                    prio_d  = prio_nxt;
                    if (gnt[1]) begin
                        op_d.we    = bus.p1_we;
                        op_d.addr  = bus.p1_addr;
                        op_d.wdata = bus.p1_wdata;
                    end else begin
                        op_d.we    = bus.p0_we;
                        op_d.addr  = bus.p0_addr;
                        op_d.wdata = bus.p0_wdata;
                    end
                    wren_d  = op_d.we;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = op_q.we ? StDone : StWait;
            end
            StWait: begin
                // RAM output is valid here, one cycle after its sampling edge.
                if (grant_q) begin
                    rdata1_d = bus.mem_q;
                end else begin
                    rdata0_d = bus.mem_q;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            prio_q   <= 1'b0;
            grant_q  <= 1'b0;
            op_q     <= '0;
            wren_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            wren_q   <= wren_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.mem_address = op_q.addr;
    assign bus.mem_data    = op_q.wdata;
    assign bus.mem_wren    = wren_q;
    assign bus.p0_ack      = (state_q == StDone) && !grant_q;
    assign bus.p1_ack      = (state_q == StDone) && grant_q;
    assign bus.p0_rdata    = rdata0_q;
    assign bus.p1_rdata    = rdata1_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.grant_id    = grant_q;

endmodule
